vsynq_generator: RTL
====================

# vsynq_generator

Vertical timing stage of the VGA controller, directly downstream of `hsynq_generator`. Counts horizontal lines by detecting the falling edge of `hsynq`, steps through the vertical sync / back porch / display / front porch phases, and drives the active-low `vsynq` and the vertical display window. Produces the combined `display` enable and the current display row for the pixel/RGB stage that follows. Default timing is 640x480@60 Hz: 521 lines per frame, 1600 `clk` cycles per line at 50 MHz.

## Interface
- `SYNC_LINES`, 2, lines in vertical sync pulse (≥1)
- `BP_LINES`, 29, back porch lines (≥1)
- `DISP_LINES`, 480, visible lines (≥1)
- `FP_LINES`, 10, front porch lines (≥1)
- `ROW_W`, 10, width of `row`; must hold `DISP_LINES-1`
- `clk`  in  1  system clock, 50 MHz
- `reset`  in  1  synchronous, active-high; one clock
- `hsynq`  in  1  active-low horizontal sync from `hsynq_generator`
- `hdisplay`  in  1  horizontal display window from `hsynq_generator`
- `vsynq`  out  1  active-low vertical sync, registered
- `vdisplay`  out  1  vertical display window, registered
- `display`  out  1  `hdisplay & vdisplay`, combinational
- `row`  out  ROW_W  visible line index 0..DISP_LINES-1; 0 outside the display phase
- `frame_start`  out  1  one-cycle pulse on entry to sync phase
- `frame_cnt`  out  8  frame counter (see Configuration)

## Operation
- Edge detect: register `hs_prev` (reset 0). Line strobe `ls = hs_prev & ~hsynq`, evaluated combinationally each cycle; `hs_prev <= hsynq` every cycle. Reset value 0 suppresses any strobe on the first cycle after reset.
- FSM states: `V_SYNC` → `V_BP` → `V_DISP` → `V_FP` → `V_SYNC`. Each state has a length: `SYNC_LINES`, `BP_LINES`, `DISP_LINES`, `FP_LINES`.
- `line_cnt` counts strobes within the current state. On `ls`:
  - If `line_cnt == len-1`: advance to the next state and clear `line_cnt` to 0.
  - Otherwise: increment `line_cnt`.
- There is no state change without `ls`.
- Registered outputs are updated at the same edge as the state:
  - `vsynq = 0` only in `V_SYNC`.
  - `vdisplay = 1` only in `V_DISP`.
  - `row = line_cnt` in `V_DISP`, else 0.
  - `frame_start = 1` for one cycle when `V_FP` → `V_SYNC`.
- Reset values: state `V_FP`, `line_cnt = FP_LINES-1`, `vsynq = 1`, `vdisplay = 0`, `row = 0`, `frame_start = 0`, `frame_cnt = 0`. As a result, the first strobe after reset opens a full frame with a `frame_start` pulse.
- `display` follows `hdisplay` with zero latency; it is 0 whenever `vdisplay = 0`.
- Reset mid-frame: all registers return to their reset values at that edge, regardless of `ls`. Reset has priority over the strobe.

## Timing
- Latency: the strobe and state update occur at the first rising edge where `hsynq` samples 0 after sampling 1. Registered outputs change immediately after that edge.
- Strobe numbering counts from reset release. Strobe 1 is the first strobe after reset.
  - Strobe 1: enter `V_SYNC`, `frame_start = 1`.
  - Strobe 3: enter `V_BP`.
  - Strobe 32: enter `V_DISP`, `row = 0`.
  - Strobe 32+k: `row = k`.
  - Strobe 512: enter `V_FP`.
  - Strobe 522: next `V_SYNC`.
- Frame period: 521 strobes = 833,600 cycles = 16.672 ms.
- `vsynq` low time: 2 lines = 3200 cycles.
- A held-low or held-high `hsynq` produces no strobes and freezes all outputs.

## Configuration
- `VSYNQ_FRAME_CNT_EN` defined:
  - `frame_cnt` increments by 1 on every `frame_start` cycle and wraps 255 → 0.
  - It is cleared by `reset`.
- `VSYNQ_FRAME_CNT_EN` undefined:
  - No counter logic is built and `frame_cnt` is tied to 8'd0.
  - The port list is identical in both builds.

## Test plan
- Reset hold: `reset = 1` for 50 cycles with `hsynq` toggling → `vsynq = 1`, `vdisplay = 0`, `row = 0`, `frame_start = 0`, `display = 0`.
- First frame: drive `hsynq` with a 1600-cycle period and 192-cycle low pulse after reset release → the first falling edge produces a one-cycle `frame_start` and `vsynq = 0`. `vsynq` stays low for exactly 3200 cycles. `vdisplay` rises at strobe 32 and falls at strobe 512.
- Row sequence: during `V_DISP`, check `row` equals the strobe index minus 32 (0..479). `row = 0` in the `V_FP` line.
- Frame period: measure between consecutive `frame_start` pulses → 833,600 cycles. `display` equals `hdisplay` only while `vdisplay = 1`.
- Mid-frame reset: assert `reset` at `row = 200` → next edge `vdisplay = 0`, `row = 0`. The first strobe after release gives `frame_start`. A strobe coincident with `reset` is ignored.
- `VSYNQ_FRAME_CNT_EN` build: run 257 frames → `frame_cnt` reaches 255 then wraps to 0 (and 1 on the 257th). Without the macro, `frame_cnt = 0` throughout.

Source files
------------

// File: rtl/vsynq_generator.sv
// vsynq_generator
// Vertical timing stage of the VGA controller. Detects falling edges of the
// horizontal sync to count lines, walks the vertical sync / back porch /
// display / front porch phases and drives vsynq, vdisplay, row, frame_start
// and the combined display enable.
//
// Optional feature: define VSYNQ_FRAME_CNT_EN to build an 8-bit wrapping
// frame counter on frame_cnt; otherwise frame_cnt is tied to zero.
module vsynq_generator #(
   parameter int SYNC_LINES = 2,
   parameter int BP_LINES   = 29,
   parameter int DISP_LINES = 480,
   parameter int FP_LINES   = 10,
   parameter int ROW_W      = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hsynq,
   input  logic             hdisplay,
   output logic             vsynq,
   output logic             vdisplay,
   output logic             display,
   output logic [ROW_W-1:0] row,
   output logic             frame_start,
   output logic [7:0]       frame_cnt
);

   // Line counter must hold the longest phase length minus one.
   localparam int MAX_AB  = (SYNC_LINES > BP_LINES) ? SYNC_LINES : BP_LINES;
   localparam int MAX_CD  = (DISP_LINES > FP_LINES) ? DISP_LINES : FP_LINES;
   localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int LC_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [1:0] {
      V_SYNC = 2'd0,
      V_BP   = 2'd1,
      V_DISP = 2'd2,
      V_FP   = 2'd3
   } vstate_e;

   vstate_e           state_q, state_d;
   logic [LC_W-1:0]   line_cnt_q, line_cnt_d;
   logic              hs_prev_q;
   logic              vsynq_q, vsynq_d;
   logic              vdisplay_q, vdisplay_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              frame_start_q, frame_start_d;
   logic              ls_s;
   logic              last_s;
   vstate_e           next_phase_s;

   // Line strobe: hsynq sampled high last cycle and low now.
   assign ls_s = hs_prev_q & ~hsynq;

   // Decode whether the current line is the last of its phase and which phase follows.
   always_comb begin
      last_s       = 1'b0;
      next_phase_s = V_SYNC;
      case (state_q)
         V_SYNC: begin
            last_s       = (line_cnt_q == LC_W'(SYNC_LINES - 1));
            next_phase_s = V_BP;
         end
         V_BP: begin
            last_s       = (line_cnt_q == LC_W'(BP_LINES - 1));
            next_phase_s = V_DISP;
         end
         V_DISP: begin
            last_s       = (line_cnt_q == LC_W'(DISP_LINES - 1));
            next_phase_s = V_FP;
         end
         V_FP: begin
            last_s       = (line_cnt_q == LC_W'(FP_LINES - 1));
            next_phase_s = V_SYNC;
         end
         default: begin
            last_s       = 1'b1;
            next_phase_s = V_SYNC;
         end
      endcase
   end

   // Next phase / line count on each strobe, and the registered output values for that phase.
   always_comb begin
      state_d       = state_q;
      line_cnt_d    = line_cnt_q;
      frame_start_d = 1'b0;
      if (ls_s) begin
         if (last_s) begin
            state_d    = next_phase_s;
            line_cnt_d = {LC_W{1'b0}};
         end else begin
            line_cnt_d = line_cnt_q + LC_W'(1);
         end
         frame_start_d = (state_q == V_FP) && (next_phase_s == V_SYNC) && last_s;
      end else begin
         state_d    = state_q;
         line_cnt_d = line_cnt_q;
      end
      vsynq_d    = (state_d != V_SYNC);
      vdisplay_d = (state_d == V_DISP);
      if (state_d == V_DISP) begin
         row_d = ROW_W'(line_cnt_d);
      end else begin
         row_d = {ROW_W{1'b0}};
      end
   end

   // Phase, line counter, edge-detect history and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= V_FP;
         line_cnt_q    <= LC_W'(FP_LINES - 1);
         hs_prev_q     <= 1'b0;
         vsynq_q       <= 1'b1;
         vdisplay_q    <= 1'b0;
         row_q         <= {ROW_W{1'b0}};
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_cnt_q    <= line_cnt_d;
         hs_prev_q     <= hsynq;
         vsynq_q       <= vsynq_d;
         vdisplay_q    <= vdisplay_d;
         row_q         <= row_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VSYNQ_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   // Frame counter steps together with the frame_start pulse and wraps naturally.
   always_comb begin
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   // Frame counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= 8'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 8'd0;
`endif

   assign vsynq       = vsynq_q;
   assign vdisplay    = vdisplay_q;
   assign row         = row_q;
   assign frame_start = frame_start_q;
   assign display     = hdisplay & vdisplay_q;

endmodule
